mem_bus_arbiter: RTL and testbench

- Parametrised successor to the single-cycle ibus/dbus-to-memory hookup: N bus masters (ibus, dbus, later DMA/debug) share one memory port.
- Round-robin arbitration, request/ack handshake on the memory side, base-address rebasing, out-of-range and timeout error responses.
- Sits in the SoC top between riscv_ic bus ports and the memory model (DPI pmem or on-chip RAM), replacing direct combinational reads.

---
 rtl/mem_bus_arbiter.sv | 209 ++++++++++++++++++++
 tb/tb_mem_bus_arbiter.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: round-robin arbiter that lets NUM_MASTERS bus masters share
// a single request/ack memory port. Addresses are rebased by BASE_ADDR, accesses
// outside the memory window and accesses the memory never acknowledges are
// answered with an error. Exactly one transaction is in flight at a time.
module mem_bus_arbiter #(
  parameter int                NUM_MASTERS = 2,
  parameter int                ADDR_W      = 32,
  parameter int                DATA_W      = 32,
  parameter int                MASK_W      = DATA_W / 8,
  parameter logic [ADDR_W-1:0] BASE_ADDR   = ADDR_W'(32'h8000_0000),
  parameter logic [ADDR_W-1:0] MEM_SIZE    = ADDR_W'(32'h0800_0000),
  parameter int                TIMEOUT     = 64
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_MASTERS-1:0]        m_req,
  input  logic [NUM_MASTERS-1:0]        m_we,
  input  logic [NUM_MASTERS*ADDR_W-1:0] m_addr,
  input  logic [NUM_MASTERS*DATA_W-1:0] m_wdata,
  input  logic [NUM_MASTERS*MASK_W-1:0] m_mask,
  output logic [NUM_MASTERS-1:0]        m_ready,
  output logic [DATA_W-1:0]             m_rdata,
  output logic                          m_err,
  output logic                          mem_req,
  output logic                          mem_we,
  output logic [ADDR_W-1:0]             mem_addr,
  output logic [DATA_W-1:0]             mem_wdata,
  output logic [MASK_W-1:0]             mem_mask,
  input  logic [DATA_W-1:0]             mem_rdata,
  input  logic                          mem_ack
);

  localparam int IDX_W = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_RESP  = 2'd2
  } state_t;

  // state, arbitration pointer and latched transaction
  state_t             r_state;
  logic [IDX_W-1:0]   r_rr;
  logic [IDX_W-1:0]   r_grant;
  logic               r_we;
  logic [ADDR_W-1:0]  r_addr;     // already rebased
  logic [DATA_W-1:0]  r_wdata;
  logic [MASK_W-1:0]  r_mask;
  logic [CNT_W-1:0]   r_cnt;

  // registered outputs
  logic [NUM_MASTERS-1:0] r_m_ready;
  logic [DATA_W-1:0]      r_m_rdata;
  logic                   r_m_err;
  logic                   r_mem_req;
  logic                   r_mem_we;
  logic [ADDR_W-1:0]      r_mem_addr;
  logic [DATA_W-1:0]      r_mem_wdata;
  logic [MASK_W-1:0]      r_mem_mask;

  // combinational arbitration / next-state values
  logic               w_found;
  logic               w_hit;
  logic [IDX_W-1:0]   w_sel;
  logic [IDX_W-1:0]   w_sel_inc;
  logic [ADDR_W-1:0]  w_cand_addr;
  logic [ADDR_W-1:0]  w_offset;
  logic               w_in_range;
  state_t             w_state_nxt;
  logic [IDX_W-1:0]   w_rr_nxt;
  logic [IDX_W-1:0]   w_grant_nxt;
  logic               w_we_nxt;
  logic [ADDR_W-1:0]  w_addr_nxt;
  logic [DATA_W-1:0]  w_wdata_nxt;
  logic [MASK_W-1:0]  w_mask_nxt;
  logic [CNT_W-1:0]   w_cnt_nxt;
  logic [DATA_W-1:0]  w_rsp_data;
  logic               w_rsp_err;

  // Pick the first requester at or after the round-robin pointer, wrapping.
  always_comb begin
    w_found = 1'b0;
    w_hit   = 1'b0;
    w_sel   = '0;
    for (int k = 0; k < NUM_MASTERS; k++) begin
      w_hit   = m_req[(int'(r_rr) + k) % NUM_MASTERS] && !w_found;
      w_sel   = w_hit ? IDX_W'((int'(r_rr) + k) % NUM_MASTERS) : w_sel;
      w_found = w_found | w_hit;
    end
    w_sel_inc   = (w_sel == IDX_W'(NUM_MASTERS - 1)) ? '0 : (w_sel + IDX_W'(1));
    w_cand_addr = m_addr[w_sel*ADDR_W +: ADDR_W];
    // Offset is only meaningful when the address is not below the base.
    w_offset    = w_cand_addr - BASE_ADDR;
    w_in_range  = (w_cand_addr >= BASE_ADDR) && (w_offset < MEM_SIZE);
  end

  // Next-state logic plus the values to be latched and presented next cycle.
  always_comb begin
    w_state_nxt = r_state;
    w_rr_nxt    = r_rr;
    w_grant_nxt = r_grant;
    w_we_nxt    = r_we;
    w_addr_nxt  = r_addr;
    w_wdata_nxt = r_wdata;
    w_mask_nxt  = r_mask;
    w_cnt_nxt   = r_cnt;
    w_rsp_data  = '0;
    w_rsp_err   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (|m_req) begin
          w_grant_nxt = w_sel;
          w_rr_nxt    = w_sel_inc;
          w_we_nxt    = m_we[w_sel];
          w_addr_nxt  = w_offset;
          w_wdata_nxt = m_wdata[w_sel*DATA_W +: DATA_W];
          w_mask_nxt  = m_mask[w_sel*MASK_W +: MASK_W];
          w_cnt_nxt   = '0;
          if (w_in_range) begin
            w_state_nxt = S_ISSUE;
          end else begin
            // Out-of-window access: answer directly, memory untouched.
            w_state_nxt = S_RESP;
            w_rsp_err   = 1'b1;
          end
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_ISSUE: begin
        if (mem_ack) begin
          // An ack in the same cycle as the last allowed wait still wins.
          w_state_nxt = S_RESP;
          w_rsp_data  = r_we ? '0 : mem_rdata;
        end else if ((TIMEOUT != 0) && (r_cnt == CNT_W'(TIMEOUT - 1))) begin
          w_state_nxt = S_RESP;
          w_rsp_err   = 1'b1;
        end else if (TIMEOUT != 0) begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end else begin
          w_cnt_nxt = r_cnt;
        end
      end
      S_RESP: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // State register and latched transaction fields.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_rr    <= '0;
      r_grant <= '0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_mask  <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_rr    <= w_rr_nxt;
      r_grant <= w_grant_nxt;
      r_we    <= w_we_nxt;
      r_addr  <= w_addr_nxt;
      r_wdata <= w_wdata_nxt;
      r_mask  <= w_mask_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Output registers: memory side only driven in ISSUE, master side only in RESP.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_m_ready   <= '0;
      r_m_rdata   <= '0;
      r_m_err     <= 1'b0;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_mem_mask  <= '0;
    end else begin
      r_m_ready   <= (w_state_nxt == S_RESP) ? (NUM_MASTERS'(1'b1) << w_grant_nxt) : '0;
      r_m_rdata   <= w_rsp_data;
      r_m_err     <= w_rsp_err;
      r_mem_req   <= (w_state_nxt == S_ISSUE);
      r_mem_we    <= (w_state_nxt == S_ISSUE) ? w_we_nxt    : 1'b0;
      r_mem_addr  <= (w_state_nxt == S_ISSUE) ? w_addr_nxt  : '0;
      r_mem_wdata <= (w_state_nxt == S_ISSUE) ? w_wdata_nxt : '0;
      r_mem_mask  <= (w_state_nxt == S_ISSUE) ? w_mask_nxt  : '0;
    end
  end

  assign m_ready   = r_m_ready;
  assign m_rdata   = r_m_rdata;
  assign m_err     = r_m_err;
  assign mem_req   = r_mem_req;
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign mem_mask  = r_mem_mask;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Testbench for mem_bus_arbiter: scenario tasks drive the masters and the memory
// side; expected responses go to a scoreboard queue that a negedge monitor pops.
module tb_mem_bus_arbiter;

  localparam int NM = 2;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int MW = DW / 8;

  logic              clk = 1'b0;
  logic              rst;
  logic [NM-1:0]     m_req;
  logic [NM-1:0]     m_we;
  logic [NM*AW-1:0]  m_addr;
  logic [NM*DW-1:0]  m_wdata;
  logic [NM*MW-1:0]  m_mask;
  logic [NM-1:0]     m_ready;
  logic [DW-1:0]     m_rdata;
  logic              m_err;
  logic              mem_req;
  logic              mem_we;
  logic [AW-1:0]     mem_addr;
  logic [DW-1:0]     mem_wdata;
  logic [MW-1:0]     mem_mask;
  logic [DW-1:0]     mem_rdata;
  logic              mem_ack;

  typedef struct {
    int            idx;
    logic [DW-1:0] data;
    logic          err;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  logic [NM-1:0] mon_oh;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_bus_arbiter #(
    .NUM_MASTERS(NM), .ADDR_W(AW), .DATA_W(DW), .MASK_W(MW),
    .BASE_ADDR(32'h8000_0000), .MEM_SIZE(32'h0800_0000), .TIMEOUT(4)
  ) dut (
    .clk(clk), .rst(rst),
    .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_mask(m_mask),
    .m_ready(m_ready), .m_rdata(m_rdata), .m_err(m_err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_mask(mem_mask), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  // Scoreboard monitor: every m_ready pulse must match the oldest expectation.
  always @(negedge clk) begin
    if (!rst) begin
      checks++;
      if (m_ready !== '0) begin
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL sb_unexpected: m_ready=%b with no expected response", m_ready);
        end else begin
          mon_e = exp_q.pop_front();
          mon_oh = '0;
          mon_oh[mon_e.idx] = 1'b1;
          if (m_ready !== mon_oh || m_rdata !== mon_e.data || m_err !== mon_e.err) begin
            errors++;
            $display("FAIL sb_resp: ready=%b rdata=%h err=%b, required ready=%b rdata=%h err=%b",
                     m_ready, m_rdata, m_err, mon_oh, mon_e.data, mon_e.err);
          end
        end
      end else if (m_rdata !== '0 || m_err !== 1'b0) begin
        errors++;
        $display("FAIL idle_resp: rdata=%h err=%b while m_ready=0, required 0/0", m_rdata, m_err);
      end
      checks++;
      if (mem_req === 1'b0 && {mem_we, mem_addr, mem_wdata, mem_mask} !== '0) begin
        errors++;
        $display("FAIL mem_idle: we=%b addr=%h wdata=%h mask=%b with mem_req=0, required all 0",
                 mem_we, mem_addr, mem_wdata, mem_mask);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive_master(input int i, input logic we, input logic [AW-1:0] addr,
                              input logic [DW-1:0] wd, input logic [MW-1:0] mk);
    m_we[i]                = we;
    m_addr[i*AW +: AW]     = addr;
    m_wdata[i*DW +: DW]    = wd;
    m_mask[i*MW +: MW]     = mk;
    m_req[i]               = 1'b1;
  endtask

  task automatic push_exp(input int idx, input logic [DW-1:0] data, input logic err);
    exp_t t;
    t.idx  = idx;
    t.data = data;
    t.err  = err;
    exp_q.push_back(t);
  endtask

  task automatic wait_mem_req(input string name);
    int n = 0;
    while (mem_req !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    checks++;
    if (mem_req !== 1'b1) begin
      errors++;
      $display("FAIL %s: mem_req=%b after %0d cycles, required 1", name, mem_req, n);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    m_req = '0; m_we = '0; m_addr = '0; m_wdata = '0; m_mask = '0;
    mem_rdata = '0; mem_ack = 1'b0;
    tick(); tick();
    checks++;
    if ({m_ready, m_rdata, m_err, mem_req, mem_we, mem_addr, mem_wdata, mem_mask} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: ready=%b rdata=%h err=%b mem_req=%b addr=%h, required all 0",
               m_ready, m_rdata, m_err, mem_req, mem_addr);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_single_read;
    drive_master(0, 1'b0, 32'h8000_0010, 32'h0, 4'hF);
    push_exp(0, 32'hDEAD_BEEF, 1'b0);
    tick();
    checks++;
    if (mem_req !== 1'b1 || mem_addr !== 32'h10 || mem_we !== 1'b0 || m_ready !== 2'b00) begin
      errors++;
      $display("FAIL read_issue: req=%b addr=%h we=%b ready=%b, required 1/00000010/0/00",
               mem_req, mem_addr, mem_we, m_ready);
    end
    mem_ack = 1'b1; mem_rdata = 32'hDEAD_BEEF;
    tick();
    mem_ack = 1'b0; mem_rdata = '0;
    checks++;
    if (m_ready !== 2'b01 || mem_req !== 1'b0) begin
      errors++;
      $display("FAIL read_latency: ready=%b mem_req=%b, required 01/0", m_ready, mem_req);
    end
    m_req[0] = 1'b0;
    tick();
  endtask

  task automatic test_masked_write;
    drive_master(1, 1'b1, 32'h8000_0004, 32'h1234_5678, 4'b0011);
    push_exp(1, 32'h0, 1'b0);
    mem_rdata = 32'hFFFF_FFFF;
    for (int k = 0; k < 4; k++) begin
      tick();
      checks++;
      if (mem_req !== 1'b1 || mem_mask !== 4'b0011 || mem_we !== 1'b1 ||
          mem_addr !== 32'h4 || mem_wdata !== 32'h1234_5678) begin
        errors++;
        $display("FAIL write_issue[%0d]: req=%b mask=%b we=%b addr=%h wdata=%h, required 1/0011/1/00000004/12345678",
                 k, mem_req, mem_mask, mem_we, mem_addr, mem_wdata);
      end
      if (k == 3) mem_ack = 1'b1;
    end
    tick();
    mem_ack = 1'b0; mem_rdata = '0;
    checks++;
    if (m_ready !== 2'b10 || mem_req !== 1'b0) begin
      errors++;
      $display("FAIL write_resp: ready=%b mem_req=%b, required 10/0", m_ready, mem_req);
    end
    m_req[1] = 1'b0; m_we[1] = 1'b0;
    tick();
  endtask

  task automatic test_contention;
    logic [AW-1:0] exp_addr;
    logic [DW-1:0] data;
    drive_master(0, 1'b0, 32'h8000_0100, 32'h0, 4'hF);
    drive_master(1, 1'b0, 32'h8000_0200, 32'h0, 4'hF);
    for (int n = 0; n < 4; n++) begin
      exp_addr = (n % 2 == 0) ? 32'h100 : 32'h200;
      data     = 32'hA000_0000 + 32'(n);
      wait_mem_req("contention_req");
      checks++;
      if (mem_addr !== exp_addr) begin
        errors++;
        $display("FAIL contention_grant[%0d]: mem_addr=%h, required %h", n, mem_addr, exp_addr);
      end
      push_exp(n % 2, data, 1'b0);
      mem_ack = 1'b1; mem_rdata = data;
      tick();
      mem_ack = 1'b0; mem_rdata = '0;
      checks++;
      if (m_ready !== ((n % 2 == 0) ? 2'b01 : 2'b10)) begin
        errors++;
        $display("FAIL contention_ready[%0d]: m_ready=%b, required one-hot master %0d", n, m_ready, n % 2);
      end
    end
    m_req = '0;
    tick();
  endtask

  task automatic test_out_of_range;
    logic [AW-1:0] bad_addr;
    for (int j = 0; j < 2; j++) begin
      bad_addr = (j == 0) ? 32'h7FFF_FFFC : 32'h8800_0000;
      drive_master(j, 1'b0, bad_addr, 32'h0, 4'hF);
      push_exp(j, 32'h0, 1'b1);
      tick();
      checks++;
      if (m_ready !== ((j == 0) ? 2'b01 : 2'b10) || mem_req !== 1'b0) begin
        errors++;
        $display("FAIL oor_resp[%0d]: ready=%b mem_req=%b, required master %0d ready and mem_req 0",
                 j, m_ready, mem_req, j);
      end
      m_req[j] = 1'b0;
      tick();
      checks++;
      if (mem_req !== 1'b0) begin
        errors++;
        $display("FAIL oor_mem[%0d]: mem_req=%b, required 0", j, mem_req);
      end
    end
  endtask

  task automatic test_timeout;
    drive_master(0, 1'b0, 32'h8000_0020, 32'h0, 4'hF);
    push_exp(0, 32'h0, 1'b1);
    for (int k = 0; k < 4; k++) begin
      tick();
      checks++;
      if (mem_req !== 1'b1) begin
        errors++;
        $display("FAIL timeout_req[%0d]: mem_req=%b, required 1", k, mem_req);
      end
    end
    tick();
    checks++;
    if (mem_req !== 1'b0 || m_ready !== 2'b01) begin
      errors++;
      $display("FAIL timeout_resp: mem_req=%b ready=%b, required 0/01", mem_req, m_ready);
    end
    m_req[0] = 1'b0;
    mem_ack = 1'b1; mem_rdata = 32'h5555_AAAA;
    for (int k = 0; k < 2; k++) begin
      tick();
      checks++;
      if (m_ready !== 2'b00 || mem_req !== 1'b0) begin
        errors++;
        $display("FAIL stray_ack[%0d]: ready=%b mem_req=%b, required 00/0", k, m_ready, mem_req);
      end
    end
    mem_ack = 1'b0; mem_rdata = '0;
    tick();
  endtask

  task automatic test_reset_mid_issue;
    drive_master(0, 1'b0, 32'h8000_0040, 32'h0, 4'hF);
    tick();
    checks++;
    if (mem_req !== 1'b1) begin
      errors++;
      $display("FAIL rst_pre: mem_req=%b, required 1", mem_req);
    end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (mem_req !== 1'b0 || m_ready !== 2'b00) begin
      errors++;
      $display("FAIL rst_async: mem_req=%b ready=%b, required 0/00", mem_req, m_ready);
    end
    m_req = '0;
    tick(); tick();
    rst = 1'b0;
    drive_master(0, 1'b0, 32'h8000_0100, 32'h0, 4'hF);
    drive_master(1, 1'b0, 32'h8000_0200, 32'h0, 4'hF);
    push_exp(0, 32'h0000_1111, 1'b0);
    tick();
    checks++;
    if (mem_req !== 1'b1 || mem_addr !== 32'h100) begin
      errors++;
      $display("FAIL rst_rr: mem_req=%b mem_addr=%h, required 1/00000100 (master 0)", mem_req, mem_addr);
    end
    mem_ack = 1'b1; mem_rdata = 32'h0000_1111;
    tick();
    mem_ack = 1'b0;
    m_req[0] = 1'b0;
    push_exp(1, 32'h0000_2222, 1'b0);
    wait_mem_req("rst_second_req");
    checks++;
    if (mem_addr !== 32'h200) begin
      errors++;
      $display("FAIL rst_second_grant: mem_addr=%h, required 00000200", mem_addr);
    end
    mem_ack = 1'b1; mem_rdata = 32'h0000_2222;
    tick();
    mem_ack = 1'b0; mem_rdata = '0;
    m_req = '0;
    tick(); tick();
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_masked_write();
    test_contention();
    test_out_of_range();
    test_timeout();
    test_reset_mid_issue();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL sb_drain: %0d responses never arrived, required 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
